// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order front end: dispatch FSM states,
// stall reason codes and default sizing taken from the build-wide defines
// ROB_SIZE_WIDTH and FLUSH_RECOVERY_CYCLES.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef FLUSH_RECOVERY_CYCLES
`define FLUSH_RECOVERY_CYCLES 2
`endif

package ooo_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALL   = 2'd1,
      RECOVER = 2'd2
   } dispatch_state_t;

   typedef enum logic [2:0] {
      SR_NONE  = 3'd0,
      SR_FLUSH = 3'd1,
      SR_ROB   = 3'd2,
      SR_REN   = 3'd3,
      SR_RS    = 3'd4
   } stall_reason_t;

   localparam int DEF_ROB_SIZE_WIDTH        = `ROB_SIZE_WIDTH;
   localparam int DEF_FLUSH_RECOVERY_CYCLES = `FLUSH_RECOVERY_CYCLES;

endpackage

// File: rtl/dispatch_credit_counter.sv
// In-flight instruction credit counter: +1 per dispatch, -1 per retire,
// synchronous clear on flush, saturates at zero and at the credit limit,
// and raises a sticky error when a retire arrives with nothing in flight.
module dispatch_credit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   input  logic         clear,
   output logic [W:0]   cnt,
   output logic         err
);

   localparam logic [W:0] LIMIT = {1'b1, {W{1'b0}}};

   logic [W:0] cnt_next;
   logic       err_next;

   // Next count: clear wins, paired inc/dec cancel, both ends saturate.
   always_comb begin
      cnt_next = cnt;
      err_next = err;
      if (clear) begin
         cnt_next = '0;
      end else if (inc && !dec) begin
         if (cnt != LIMIT) cnt_next = cnt + 1'b1;
      end else if (dec && !inc) begin
         if (cnt != '0) cnt_next = cnt - 1'b1;
      end
      // A retire in a flush cycle is discarded, so it cannot flag an error.
      if (!clear && dec && (cnt == '0)) err_next = 1'b1;
   end

   // Count and sticky error registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_next;
         err <= err_next;
      end
   end

endmodule

// File: rtl/dispatch_stall_ctrl.sv
// Decode-rename issue/stall sequencer. Combinational stall/fetch_hold from
// ROB, rename and RS status plus a RUN/STALL/RECOVER FSM with a fixed
// post-flush recovery window. Optional performance counters are built when
// DISPATCH_PERF_CNT_EN is defined; otherwise the perf_* ports read zero.
module dispatch_stall_ctrl
   import ooo_pkg::*;
#(
   parameter int ROB_SIZE_WIDTH        = DEF_ROB_SIZE_WIDTH,
   parameter int FLUSH_RECOVERY_CYCLES = DEF_FLUSH_RECOVERY_CYCLES,
   parameter int PERF_CNT_WIDTH        = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dispatch_pending,
   input  logic                        rob_full,
   input  logic                        can_rename,
   input  logic                        rs_full,
   input  logic                        retire_tag_valid,
   input  logic                        flush,
   output logic                        stall,
   output logic                        fetch_hold,
   output logic                        dispatch_fire,
   output stall_reason_t               stall_reason,
   output logic [ROB_SIZE_WIDTH:0]     inflight_cnt,
   output logic                        credit_err,
   output logic [PERF_CNT_WIDTH-1:0]   perf_stall_cyc,
   output logic [PERF_CNT_WIDTH-1:0]   perf_recover_cyc,
   output logic [PERF_CNT_WIDTH-1:0]   perf_issued
);

   localparam int RW = (FLUSH_RECOVERY_CYCLES > 1) ? $clog2(FLUSH_RECOVERY_CYCLES) : 1;
   localparam logic [RW-1:0] RLOAD = RW'(FLUSH_RECOVERY_CYCLES - 1);
   localparam logic [ROB_SIZE_WIDTH:0] LIMIT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

   dispatch_state_t state_reg, state_next;
   logic [RW-1:0]   rcnt_reg, rcnt_next;
   logic            credit_full, res_ok, in_recover, stall_int;

   assign credit_full   = (inflight_cnt >= LIMIT);
   assign res_ok        = !rob_full && can_rename && !rs_full && !credit_full;
   assign in_recover    = (state_reg == RECOVER);
   assign stall_int     = in_recover || flush || !res_ok;

   // Reset forces a safe, fully held front end regardless of inputs.
   assign stall         = reset || stall_int;
   assign fetch_hold    = reset || (stall_int && dispatch_pending) || in_recover || flush;
   assign dispatch_fire = !reset && dispatch_pending && !stall_int;

   // Stall reason in priority order: flush/recovery, ROB or credits, rename, RS.
   always_comb begin
      stall_reason = SR_NONE;
      if (reset)                         stall_reason = SR_NONE;
      else if (in_recover || flush)      stall_reason = SR_FLUSH;
      else if (rob_full || credit_full)  stall_reason = SR_ROB;
      else if (!can_rename)              stall_reason = SR_REN;
      else if (rs_full)                  stall_reason = SR_RS;
   end

   // FSM next state and recovery countdown; a flush always (re)starts recovery.
   always_comb begin
      state_next = state_reg;
      rcnt_next  = rcnt_reg;
      if (flush) begin
         state_next = RECOVER;
         rcnt_next  = RLOAD;
      end else begin
         case (state_reg)
            RUN:     if (dispatch_pending && !res_ok) state_next = STALL;
            STALL:   if (res_ok) state_next = RUN;
            RECOVER: begin
               if (rcnt_reg == '0) state_next = RUN;
               else                rcnt_next  = rcnt_reg - 1'b1;
            end
            default: state_next = RUN;
         endcase
      end
   end

   // FSM state and recovery counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= RUN;
         rcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         rcnt_reg  <= rcnt_next;
      end
   end

   dispatch_credit_counter #(
      .W (ROB_SIZE_WIDTH)
   ) u_credit (
      .clk   (clk),
      .reset (reset),
      .inc   (dispatch_fire),
      .dec   (retire_tag_valid),
      .clear (flush),
      .cnt   (inflight_cnt),
      .err   (credit_err)
   );

`ifdef DISPATCH_PERF_CNT_EN
   // Free-running performance counters, wrapping at their width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cyc   <= '0;
         perf_recover_cyc <= '0;
         perf_issued      <= '0;
      end else begin
         if (dispatch_pending && stall_int) perf_stall_cyc   <= perf_stall_cyc + 1'b1;
         if (in_recover)                    perf_recover_cyc <= perf_recover_cyc + 1'b1;
         if (dispatch_fire)                 perf_issued      <= perf_issued + 1'b1;
      end
   end
`else
   assign perf_stall_cyc   = '0;
   assign perf_recover_cyc = '0;
   assign perf_issued      = '0;
`endif

endmodule

// File: tb/tb_dispatch_stall_ctrl.sv
// Scoreboard bench for dispatch_stall_ctrl (ROB_SIZE_WIDTH=2, recovery 2).
// Stimulus pushes the hand-computed expected outputs of each cycle; the
// monitor pops and compares them on the falling edge.
module tb_dispatch_stall_ctrl;
   import ooo_pkg::*;

`ifdef DISPATCH_PERF_CNT_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic dispatch_pending, rob_full, can_rename, rs_full, retire_tag_valid, flush;
   logic stall, fetch_hold, dispatch_fire, credit_err;
   stall_reason_t stall_reason;
   logic [2:0]  inflight_cnt;
   logic [31:0] perf_stall_cyc, perf_recover_cyc, perf_issued;

   always #5 clk = ~clk;

   dispatch_stall_ctrl #(
      .ROB_SIZE_WIDTH        (2),
      .FLUSH_RECOVERY_CYCLES (2),
      .PERF_CNT_WIDTH        (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .dispatch_pending (dispatch_pending),
      .rob_full         (rob_full),
      .can_rename       (can_rename),
      .rs_full          (rs_full),
      .retire_tag_valid (retire_tag_valid),
      .flush            (flush),
      .stall            (stall),
      .fetch_hold       (fetch_hold),
      .dispatch_fire    (dispatch_fire),
      .stall_reason     (stall_reason),
      .inflight_cnt     (inflight_cnt),
      .credit_err       (credit_err),
      .perf_stall_cyc   (perf_stall_cyc),
      .perf_recover_cyc (perf_recover_cyc),
      .perf_issued      (perf_issued)
   );

   typedef struct {
      string         nm;
      logic          st, hd, fi;
      stall_reason_t rs;
      int            cnt;
      logic          err;
      bit            chkp;
      int            ps, pr, pi;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   perf_req = 1'b0;
   int   perf_ps, perf_pr, perf_pi;

   task automatic chk(input string nm, input string field, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, field, act, req);
      end
   endtask

   // Monitor: one comparison set per cycle the stimulus scheduled.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "stall",  int'(stall),         int'(e.st));
            chk(e.nm, "hold",   int'(fetch_hold),    int'(e.hd));
            chk(e.nm, "fire",   int'(dispatch_fire), int'(e.fi));
            chk(e.nm, "reason", int'(stall_reason),  int'(e.rs));
            chk(e.nm, "cnt",    int'(inflight_cnt),  e.cnt);
            chk(e.nm, "err",    int'(credit_err),    int'(e.err));
            if (e.chkp) begin
               chk(e.nm, "perf_stall",   int'(perf_stall_cyc),   e.ps);
               chk(e.nm, "perf_recover", int'(perf_recover_cyc), e.pr);
               chk(e.nm, "perf_issued",  int'(perf_issued),      e.pi);
            end
            $display("cycle %-10s pend=%0b st=%0b hd=%0b fi=%0b rsn=%0d cnt=%0d err=%0b",
                     e.nm, dispatch_pending, stall, fetch_hold, dispatch_fire,
                     int'(stall_reason), inflight_cnt, credit_err);
         end
      end
   end

   // Request perf counter checks on the next step (zero without the feature).
   task automatic perf_next(input int ps, input int pr, input int pi);
      perf_req = 1'b1;
      perf_ps  = PERF_ON ? ps : 0;
      perf_pr  = PERF_ON ? pr : 0;
      perf_pi  = PERF_ON ? pi : 0;
   endtask

   task automatic go(input logic rst, pend, rob, ren, rs, ret, fl,
                     input logic e_st, e_hd, e_fi, input stall_reason_t e_rs,
                     input int e_cnt, input logic e_err, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset            = rst;
      dispatch_pending = pend;
      rob_full         = rob;
      can_rename       = ren;
      rs_full          = rs;
      retire_tag_valid = ret;
      flush            = fl;
      e.nm = nm; e.st = e_st; e.hd = e_hd; e.fi = e_fi; e.rs = e_rs;
      e.cnt = e_cnt; e.err = e_err;
      e.chkp = perf_req; e.ps = perf_ps; e.pr = perf_pr; e.pi = perf_pi;
      perf_req = 1'b0;
      exp_q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; dispatch_pending = 1'b1; rob_full = 1'b1; can_rename = 1'b1;
      rs_full = 1'b0; retire_tag_valid = 1'b0; flush = 1'b0;
      //          rst p rob ren rs ret fl   st hd fi reason    cnt err
      perf_next(0, 0, 0);
      go(1, 1, 1, 1, 0, 0, 0,   1, 1, 0, SR_NONE,  0, 0, "rst0");
      go(1, 1, 0, 1, 0, 0, 0,   1, 1, 0, SR_NONE,  0, 0, "rst1");
      // Free resources: fire each cycle until the 4-credit limit.
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  0, 0, "fire0");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  1, 0, "fire1");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  2, 0, "fire2");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  3, 0, "fire3");
      go(0, 1, 0, 1, 0, 0, 0,   1, 1, 0, SR_ROB,   4, 0, "limit");
      go(0, 1, 0, 1, 0, 1, 0,   1, 1, 0, SR_ROB,   4, 0, "lim_ret");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  3, 0, "refire");
      go(0, 1, 0, 1, 0, 1, 0,   1, 1, 0, SR_ROB,   4, 0, "lim_ret2");
      go(0, 1, 0, 1, 0, 1, 0,   0, 0, 1, SR_NONE,  3, 0, "fire_ret");
      go(0, 0, 0, 1, 0, 1, 0,   0, 0, 0, SR_NONE,  3, 0, "drain3");
      go(0, 0, 0, 1, 0, 1, 0,   0, 0, 0, SR_NONE,  2, 0, "drain2");
      go(0, 0, 0, 1, 0, 1, 0,   0, 0, 0, SR_NONE,  1, 0, "drain1");
      // ROB full for three cycles, then release fires immediately.
      go(0, 1, 1, 1, 0, 0, 0,   1, 1, 0, SR_ROB,   0, 0, "robf0");
      go(0, 1, 1, 1, 0, 0, 0,   1, 1, 0, SR_ROB,   0, 0, "robf1");
      go(0, 1, 1, 1, 0, 0, 0,   1, 1, 0, SR_ROB,   0, 0, "robf2");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  0, 0, "robrel");
      // Reason priority and fetch_hold without a pending instruction.
      go(0, 1, 0, 0, 0, 0, 0,   1, 1, 0, SR_REN,   1, 0, "ren");
      go(0, 1, 0, 1, 1, 0, 0,   1, 1, 0, SR_RS,    1, 0, "rs");
      go(0, 0, 0, 0, 1, 0, 0,   1, 0, 0, SR_REN,   1, 0, "ren_idle");
      go(0, 1, 1, 0, 1, 0, 0,   1, 1, 0, SR_ROB,   1, 0, "prio");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  1, 0, "fire4");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  2, 0, "fire5");
      // Flush at 3 in flight with pending and retire: no fire, credits cleared.
      go(0, 1, 0, 1, 0, 1, 1,   1, 1, 0, SR_FLUSH, 3, 0, "flush");
      go(0, 1, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "recov1");
      go(0, 1, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "recov2");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  0, 0, "postrec");
      // Second flush inside recovery restarts the window.
      go(0, 0, 0, 1, 0, 0, 1,   1, 1, 0, SR_FLUSH, 1, 0, "flushA");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "recA1");
      go(0, 0, 0, 1, 0, 0, 1,   1, 1, 0, SR_FLUSH, 0, 0, "flushB");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "recB1");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "recB2");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  0, 0, "postB");
      // Retire with nothing in flight: sticky credit error.
      go(0, 0, 0, 1, 0, 1, 0,   0, 0, 0, SR_NONE,  1, 0, "ret1");
      go(0, 0, 0, 1, 0, 1, 0,   0, 0, 0, SR_NONE,  0, 0, "ret_at0");
      go(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, SR_NONE,  0, 1, "err_set");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  0, 1, "err_fire");
      go(0, 0, 0, 1, 0, 0, 1,   1, 1, 0, SR_FLUSH, 1, 1, "err_flush");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 1, "err_rec1");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 1, "err_rec2");
      go(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, SR_NONE,  0, 1, "err_keep");
      // Mid-run async reset clears everything, then perf scenario.
      perf_next(0, 0, 0);
      go(1, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_NONE,  0, 0, "rst_mid");
      for (int i = 0; i < 5; i++)
         go(0, 1, 1, 1, 0, 0, 0, 1, 1, 0, SR_ROB,   0, 0, "p_stall");
      go(0, 1, 0, 1, 0, 0, 0,   0, 0, 1, SR_NONE,  0, 0, "p_fire");
      for (int i = 0; i < 6; i++)
         go(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, SR_NONE,  1, 0, "p_fireret");
      perf_next(5, 0, 7);
      go(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, SR_NONE,  1, 0, "p_chk1");
      go(0, 0, 0, 1, 0, 0, 1,   1, 1, 0, SR_FLUSH, 1, 0, "p_flush");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "p_rec1");
      go(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, SR_FLUSH, 0, 0, "p_rec2");
      perf_next(5, 2, 7);
      go(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, SR_NONE,  0, 0, "p_chk2");

      // Give the monitor a bounded window to drain the scoreboard.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain", "left", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
